sdram_arbiter_nch: RTL

Parametrised N-channel SDRAM arbiter sitting between the single-port SDRAM controller and all bus masters (video scanout, CPU, future blitter/audio DMA). Channel 0 is the fixed highest-priority port (video); channels 1..NUM_CH-1 share the remaining bandwidth by round-robin. It holds a grant for one whole transaction (request through ack), masks controller readiness for a programmable number of wait states, and drives per-channel burst mode from a parameter mask.

---
 rtl/sdram_arbiter_nch_if.sv | 64 ++++++
 rtl/sdram_arbiter_nch.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_nch_if.sv
// ----------------------------------------------------------------------------
// sdram_arbiter_nch_if
//   Bundles every bus signal around the N-channel SDRAM arbiter: the
//   per-channel master side (packed, channel i in slice [i*W +: W]) and the
//   single SDRAM controller side.
//
//   modport slave  : the arbiter itself. It takes channel requests and
//                    controller read data/ready, and drives grants and strobes.
//   modport master : the surroundings, meaning the bus masters plus the
//                    controller.
//
//   Signals
//     ch_rd_i / ch_wr_i   per-channel read / write request
//     ch_addr_x16_i       per-channel word address
//     ch_wdata_i          per-channel write data
//     ch_wmask_i          per-channel byte write mask
//     ch_ack_i            per-channel transaction acknowledge
//     ch_rdy_o            per-channel ready (at most one bit set)
//     ch_rdata_o          read data broadcast to all channels
//     grant_o             one-hot current grant, 0 when idle
//     sdram_*             controller strobes, address, data, mask, ack, burst
//     sdram_rdata/_rdy    controller read data and ready
// ----------------------------------------------------------------------------
interface sdram_arbiter_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]          ch_rd_i;
  logic [NUM_CH-1:0]          ch_wr_i;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr_x16_i;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata_i;
  logic [NUM_CH*DATA_W/8-1:0] ch_wmask_i;
  logic [NUM_CH-1:0]          ch_ack_i;
  logic [NUM_CH-1:0]          ch_rdy_o;
  logic [DATA_W-1:0]          ch_rdata_o;
  logic [NUM_CH-1:0]          grant_o;

  logic                       sdram_rd;
  logic                       sdram_wr;
  logic [ADDR_W-1:0]          sdram_addr_x16;
  logic [DATA_W-1:0]          sdram_wdata;
  logic [DATA_W/8-1:0]        sdram_wmask;
  logic                       sdram_ack;
  logic                       sdram_burst;
  logic [DATA_W-1:0]          sdram_rdata;
  logic                       sdram_rdy;

  modport slave (
    input  ch_rd_i, ch_wr_i, ch_addr_x16_i, ch_wdata_i, ch_wmask_i, ch_ack_i,
    input  sdram_rdata, sdram_rdy,
    output ch_rdy_o, ch_rdata_o, grant_o,
    output sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    output sdram_ack, sdram_burst
  );

  modport master (
    output ch_rd_i, ch_wr_i, ch_addr_x16_i, ch_wdata_i, ch_wmask_i, ch_ack_i,
    output sdram_rdata, sdram_rdy,
    input  ch_rdy_o, ch_rdata_o, grant_o,
    input  sdram_rd, sdram_wr, sdram_addr_x16, sdram_wdata, sdram_wmask,
    input  sdram_ack, sdram_burst
  );
endinterface

// File: rtl/sdram_arbiter_nch.sv
// ----------------------------------------------------------------------------
// sdram_arbiter_nch
//   N-channel arbiter in front of the single-port SDRAM controller.
//   Channel 0 (video) has fixed top priority. Channels 1..NUM_CH-1 share the
//   rest of the bandwidth. A grant is held for the whole transaction, from
//   request through ack. After each grant, controller ready is masked for
//   WAITSTATES cycles. BURST_MASK sets sdram_burst for each channel.
//
//   Configuration macro
//     SDRAM_ARB_RR_EN  defined  : round-robin among channels 1..NUM_CH-1
//                      undefined: fixed priority, lowest requesting index wins
//
//   Ports
//     clk_i   system clock
//     rst_i   synchronous, active-high reset (aborts any grant)
//     bus     sdram_arbiter_nch_if.slave. Holds channel requests, address,
//             data, mask and ack in; ready, read data and grant out; and the
//             controller-side strobes, address, data, mask, ack and burst.
// ----------------------------------------------------------------------------
module sdram_arbiter_nch #(
  parameter int                NUM_CH     = 3,
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter int                WAITSTATES = 2,
  parameter logic [NUM_CH-1:0] BURST_MASK = {{(NUM_CH-1){1'b0}}, 1'b1}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sdram_arbiter_nch_if.slave  bus
);

  localparam int       IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int       MASK_W = DATA_W / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Registered control state
  logic [0:0]        state_p1;
  logic [NUM_CH-1:0] grant_p1;
  logic [3:0]        ws_cnt_p1;
`ifdef SDRAM_ARB_RR_EN
  logic [IDX_W-1:0]  rr_last_p1;
  logic [IDX_W-1:0]  sel_idx_p0;
`endif

  logic [NUM_CH-1:0] req_p0;
  logic [NUM_CH-1:0] sel_oh_p0;
  logic              found_p0;
  logic              ack_hit_p0;

  logic              rd_g_p1;
  logic              wr_g_p1;
  logic              ack_g_p1;
  logic [ADDR_W-1:0] addr_g_p1;
  logic [DATA_W-1:0] wdata_g_p1;
  logic [MASK_W-1:0] wmask_g_p1;

  // ---- stage p0: request collection and selection ----
  assign req_p0     = bus.ch_rd_i | bus.ch_wr_i;
  assign ack_hit_p0 = |(bus.ch_ack_i & grant_p1);

`ifdef SDRAM_ARB_RR_EN
  // Channel 0 preempts the scan. The round-robin ring covers channels
  // 1..NUM_CH-1 only. Candidate k (1-based) is the channel k places past
  // rr_last on that ring.
  always_comb begin
    sel_oh_p0  = '0;
    sel_idx_p0 = '0;
    found_p0   = 1'b0;
    if (req_p0[0]) begin
      sel_oh_p0[0] = 1'b1;
      found_p0     = 1'b1;
    end else begin
      for (int k = 1; k < NUM_CH; k++) begin
        for (int j = 1; j < NUM_CH; j++) begin
          if (!found_p0 && req_p0[j] &&
              (j == ((int'(rr_last_p1) - 1 + k) % (NUM_CH - 1)) + 1)) begin
            found_p0     = 1'b1;
            sel_oh_p0[j] = 1'b1;
            sel_idx_p0   = IDX_W'(j);
          end
        end
      end
    end
  end
`else
  always_comb begin
    sel_oh_p0 = '0;
    found_p0  = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found_p0 && req_p0[j]) begin
        found_p0     = 1'b1;
        sel_oh_p0[j] = 1'b1;
      end
    end
  end
`endif

  // ---- stage p1: grant / wait-state registers ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1   <= ST_IDLE;
      grant_p1   <= '0;
      ws_cnt_p1  <= 4'd0;
`ifdef SDRAM_ARB_RR_EN
      rr_last_p1 <= IDX_W'(NUM_CH - 1);
`endif
    end else begin
      case (state_p1)
        ST_IDLE: begin
          if (found_p0) begin
            state_p1  <= ST_BUSY;
            grant_p1  <= sel_oh_p0;
            ws_cnt_p1 <= 4'(WAITSTATES);
`ifdef SDRAM_ARB_RR_EN
            if (sel_idx_p0 != '0) begin
              rr_last_p1 <= sel_idx_p0;
            end
`endif
          end
        end
        ST_BUSY: begin
          if (ws_cnt_p1 != 4'd0) begin
            ws_cnt_p1 <= ws_cnt_p1 - 4'd1;
          end
          if (ack_hit_p0) begin
            state_p1 <= ST_IDLE;
            grant_p1 <= '0;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
          grant_p1 <= '0;
        end
      endcase
    end
  end

  // ---- stage p1 outputs: AND-OR mux from the one-hot grant ----
  // With no grant every term is zero, so the idle outputs are a clean 0.
  always_comb begin
    rd_g_p1    = 1'b0;
    wr_g_p1    = 1'b0;
    ack_g_p1   = 1'b0;
    addr_g_p1  = '0;
    wdata_g_p1 = '0;
    wmask_g_p1 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_p1[i]) begin
        rd_g_p1    = rd_g_p1  | bus.ch_rd_i[i];
        wr_g_p1    = wr_g_p1  | bus.ch_wr_i[i];
        ack_g_p1   = ack_g_p1 | bus.ch_ack_i[i];
        addr_g_p1  = addr_g_p1  | bus.ch_addr_x16_i[i*ADDR_W +: ADDR_W];
        wdata_g_p1 = wdata_g_p1 | bus.ch_wdata_i[i*DATA_W +: DATA_W];
        wmask_g_p1 = wmask_g_p1 | bus.ch_wmask_i[i*MASK_W +: MASK_W];
      end
    end
  end

  // A write takes precedence when a master raises rd and wr together.
  assign bus.sdram_rd       = rd_g_p1 & ~wr_g_p1;
  assign bus.sdram_wr       = wr_g_p1;
  assign bus.sdram_ack      = ack_g_p1;
  assign bus.sdram_addr_x16 = addr_g_p1;
  assign bus.sdram_wdata    = wdata_g_p1;
  assign bus.sdram_wmask    = wmask_g_p1;
  assign bus.sdram_burst    = |(grant_p1 & BURST_MASK);
  assign bus.ch_rdy_o       = grant_p1 &
                              {NUM_CH{bus.sdram_rdy & (ws_cnt_p1 == 4'd0)}};
  assign bus.ch_rdata_o     = bus.sdram_rdata;
  assign bus.grant_o        = grant_p1;

endmodule
